// File: rtl/fib_05_rewind.sv
// Reversible fib_05 stepping engine: forward steps push the selector onto a LIFO history,
// rewind pops it and applies the exact inverse step until the state returns to zero.
module fib_05_rewind #(
    parameter int W     = 11,
    parameter int LIMIT = 300,
    parameter int DEPTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         selector,
    input  logic                         go,
    input  logic                         rewind,
    output logic [W-1:0]                 x,
    output logic [W-1:0]                 y,
    output logic [W-1:0]                 i,
    output logic [W-1:0]                 j,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         full,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam logic [W-1:0]  LIM = W'(LIMIT);
    localparam logic [DW-1:0] DEP = DW'(DEPTH);

    typedef enum logic [1:0] {IDLE, FWD, REWIND, DONE} state_t;

    state_t            state, state_n;
    logic [W-1:0]      x_n, y_n, i_n, j_n;
    logic [DW-1:0]     depth_n;
    logic              err_n;
    logic              push;
    logic [DEPTH-1:0]  stack;
    logic              top;

    always_comb begin
        top = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (DW'(k + 1) == depth) top = stack[k];
        end
    end

    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        i_n     = i;
        j_n     = j;
        depth_n = depth;
        err_n   = err;
        push    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (go) begin
                    state_n = FWD;
                    err_n   = 1'b0;
                end
            end
            FWD: begin
                if (rewind) begin
                    state_n = REWIND;
                end else if (j < LIM && depth != DEP) begin
                    push    = 1'b1;
                    x_n     = x + W'(1);
                    y_n     = y + W'(1);
                    i_n     = i + x + W'(1);
                    j_n     = selector ? (j + y + W'(1)) : (j + y + W'(2));
                    depth_n = depth + DW'(1);
                end
            end
            REWIND: begin
                // inverse uses the pre-edge x/y, which equal the forward step's post-edge values
                if (depth != '0) begin
                    x_n     = x - W'(1);
                    y_n     = y - W'(1);
                    i_n     = i - x;
                    j_n     = top ? (j - y) : (j - y - W'(1));
                    depth_n = depth - DW'(1);
                end else begin
                    state_n = DONE;
                    if ((x | y | i | j) != '0) err_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (j < i) err_n = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x     <= '0;
            y     <= '0;
            i     <= '0;
            j     <= '0;
            depth <= '0;
            err   <= 1'b0;
            stack <= '0;
        end else begin
            x     <= x_n;
            y     <= y_n;
            i     <= i_n;
            j     <= j_n;
            depth <= depth_n;
            err   <= err_n;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (push && DW'(k) == depth) stack[k] <= selector;
            end
        end
    end

    assign full = (depth == DEP);
    assign busy = (state == FWD) || (state == REWIND);
    assign done = (state == DONE);

endmodule

// File: tb/tb_fib_05_rewind.sv
// Bench for fib_05_rewind: vector table, hand-written corner sequences and randomized
// stimulus checked against a queue-based reference model of the default instance.
module tb_fib_05_rewind;

    localparam int W       = 11;
    localparam int LIMIT   = 300;
    localparam int DEPTH_A = 32;
    localparam int DEPTH_B = 8;
    localparam int MASK    = (1 << W) - 1;
    localparam int P_IDLE = 0, P_FWD = 1, P_REW = 2, P_DONE = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic selector = 1'b0, go = 1'b0, rewind = 1'b0;

    logic [W-1:0] a_x, a_y, a_i, a_j;
    logic [5:0]   a_depth;
    logic         a_full, a_busy, a_done, a_err;
    logic [W-1:0] b_x, b_y, b_i, b_j;
    logic [3:0]   b_depth;
    logic         b_full, b_busy, b_done, b_err;

    fib_05_rewind #(.W(W), .LIMIT(LIMIT), .DEPTH(DEPTH_A)) dut_a (
        .clk(clk), .rst(rst), .selector(selector), .go(go), .rewind(rewind),
        .x(a_x), .y(a_y), .i(a_i), .j(a_j), .depth(a_depth),
        .full(a_full), .busy(a_busy), .done(a_done), .err(a_err)
    );

    fib_05_rewind #(.W(W), .LIMIT(LIMIT), .DEPTH(DEPTH_B)) dut_b (
        .clk(clk), .rst(rst), .selector(selector), .go(go), .rewind(rewind),
        .x(b_x), .y(b_y), .i(b_i), .j(b_j), .depth(b_depth),
        .full(b_full), .busy(b_busy), .done(b_done), .err(b_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int mx, my, mi, mj, mphase;
    bit merr;
    bit hist[$];

    typedef struct {
        bit go; bit rw; bit sel;
        int ex; int ey; int ei; int ej; int ed;
        bit edone;
    } vec_t;
    vec_t tbl[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 0; mi = 0; mj = 0;
        mphase = P_IDLE;
        merr = 1'b0;
        hist.delete();
    endtask

    task automatic model_edge(input bit g, input bit rw, input bit s);
        bit mon = (mj < mi);
        bit b;
        case (mphase)
            P_IDLE, P_DONE: if (g) begin mphase = P_FWD; merr = 1'b0; end
            P_FWD: begin
                if (rw) mphase = P_REW;
                else if (mj < LIMIT && hist.size() < DEPTH_A) begin
                    hist.push_back(s);
                    mi = (mi + mx + 1) & MASK;
                    mj = (mj + my + (s ? 1 : 2)) & MASK;
                    mx = (mx + 1) & MASK;
                    my = (my + 1) & MASK;
                end
            end
            P_REW: begin
                if (hist.size() > 0) begin
                    b = hist.pop_back();
                    mi = (mi - mx) & MASK;
                    mj = (mj - my - (b ? 0 : 1)) & MASK;
                    mx = (mx - 1) & MASK;
                    my = (my - 1) & MASK;
                end else begin
                    mphase = P_DONE;
                    if ((mx | my | mi | mj) != 0) merr = 1'b1;
                end
            end
            default: mphase = P_IDLE;
        endcase
        if (mon) merr = 1'b1;
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".x"}, int'(a_x), mx);
        check({tag, ".y"}, int'(a_y), my);
        check({tag, ".i"}, int'(a_i), mi);
        check({tag, ".j"}, int'(a_j), mj);
        check({tag, ".depth"}, int'(a_depth), hist.size());
        check({tag, ".full"}, int'(a_full), int'(hist.size() == DEPTH_A));
        check({tag, ".busy"}, int'(a_busy), int'(mphase == P_FWD || mphase == P_REW));
        check({tag, ".done"}, int'(a_done), int'(mphase == P_DONE));
        check({tag, ".err"}, int'(a_err), int'(merr));
    endtask

    task automatic cycle(input bit g, input bit rw, input bit s, input string tag);
        go = g; rewind = rw; selector = s;
        @(posedge clk);
        model_edge(g, rw, s);
        #1;
        go = 1'b0; rewind = 1'b0;
        compare_model(tag);
    endtask

    task automatic expect_a(input string tag, input int ex, input int ey, input int ei,
                            input int ej, input int ed, input bit edone, input bit eerr);
        check({tag, ".x"}, int'(a_x), ex);
        check({tag, ".y"}, int'(a_y), ey);
        check({tag, ".i"}, int'(a_i), ei);
        check({tag, ".j"}, int'(a_j), ej);
        check({tag, ".depth"}, int'(a_depth), ed);
        check({tag, ".done"}, int'(a_done), int'(edone));
        check({tag, ".err"}, int'(a_err), int'(eerr));
    endtask

    // Asynchronous reset: outputs are checked before any clock edge arrives.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check({tag, ".rst_zero"}, int'({a_x, a_y, a_i, a_j, a_depth, a_full, a_busy, a_done, a_err}), 0);
        check({tag, ".rst_zero_b"}, int'({b_x, b_y, b_i, b_j, b_depth, b_full, b_busy, b_done, b_err}), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 0, 0, 1, 1, 1, 2, 1, 0};
        tbl[2] = '{0, 0, 1, 2, 2, 3, 4, 2, 0};
        tbl[3] = '{0, 1, 0, 2, 2, 3, 4, 2, 0};
        tbl[4] = '{0, 0, 0, 1, 1, 1, 2, 1, 0};
        tbl[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[6] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};

        do_reset("reset0");

        for (int n = 0; n < 7; n++) begin
            cycle(tbl[n].go, tbl[n].rw, tbl[n].sel, $sformatf("tbl%0d", n));
            expect_a($sformatf("tblc%0d", n), tbl[n].ex, tbl[n].ey, tbl[n].ei, tbl[n].ej,
                     tbl[n].ed, tbl[n].edone, 1'b0);
        end

        // selector=1 stops at the LIMIT after 24 steps
        cycle(1, 0, 0, "s1go");
        for (int n = 0; n < 30; n++) cycle(0, 0, 1, "s1fwd");
        expect_a("s1end", 24, 24, 300, 300, 24, 1'b0, 1'b0);
        check("s1full", int'(a_full), 0);
        cycle(0, 1, 0, "s1rw");
        for (int n = 0; n < 24; n++) cycle(0, 0, 0, "s1pop");
        expect_a("s1zero", 0, 0, 0, 0, 0, 1'b0, 1'b0);
        cycle(0, 0, 0, "s1done");
        expect_a("s1fin", 0, 0, 0, 0, 0, 1'b1, 1'b0);
        cycle(0, 0, 0, "s1hold");
        check("s1hold.done", int'(a_done), 1);

        // selector=0 reaches j = 324
        cycle(1, 0, 0, "s0go");
        for (int n = 0; n < 30; n++) cycle(0, 0, 0, "s0fwd");
        expect_a("s0end", 24, 24, 300, 324, 24, 1'b0, 1'b0);
        cycle(0, 1, 0, "s0rw");
        for (int n = 0; n < 24; n++) cycle(0, 0, 1, "s0pop");
        expect_a("s0zero", 0, 0, 0, 0, 0, 1'b0, 1'b0);
        cycle(0, 0, 0, "s0done");
        expect_a("s0fin", 0, 0, 0, 0, 0, 1'b1, 1'b0);

        // small instance fills its stack
        do_reset("reset_b");
        cycle(1, 0, 0, "bgo");
        for (int n = 0; n < 10; n++) cycle(0, 0, 1, "bfwd");
        check("b.x", int'(b_x), 8);
        check("b.i", int'(b_i), 36);
        check("b.j", int'(b_j), 36);
        check("b.full", int'(b_full), 1);
        cycle(0, 1, 0, "brw");
        for (int n = 0; n < 8; n++) cycle(0, 0, 0, "bpop");
        check("b.zero", int'({b_x, b_y, b_i, b_j, b_depth}), 0);
        check("b.notdone", int'(b_done), 0);
        cycle(0, 0, 0, "bdone");
        check("b.done", int'(b_done), 1);
        check("b.err", int'(b_err), 0);
        for (int n = 0; n < 3; n++) cycle(0, 0, 0, "aflush");

        // rewind beats a step; go while busy is ignored
        do_reset("reset_p");
        cycle(1, 0, 0, "pgo");
        for (int n = 0; n < 3; n++) cycle(0, 0, n[0], "pfwd");
        cycle(0, 1, 1, "prw");
        check("prio.depth", int'(a_depth), 3);
        check("prio.x", int'(a_x), 3);
        cycle(1, 0, 0, "pgo_busy");
        check("gobusy.busy", int'(a_busy), 1);
        check("gobusy.depth", int'(a_depth), 2);

        // async reset mid-rewind at depth 5
        do_reset("reset_r");
        cycle(1, 0, 0, "rgo");
        for (int n = 0; n < 7; n++) cycle(0, 0, 1'($urandom_range(0, 1)), "rfwd");
        cycle(0, 1, 0, "rrw");
        cycle(0, 0, 0, "rpop");
        cycle(0, 0, 0, "rpop");
        check("mid.depth", int'(a_depth), 5);
        do_reset("mid_rst");
        cycle(0, 0, 0, "post_rst");

        // randomized run against the model
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset("rand_rst");
            cycle(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 1)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
